// File: rtl/fifo_pkg.sv
// Shared types and defaults for the sync_fifo read-side adapter.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;
  localparam int unsigned OCC_WIDTH          = 2;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_e;

  // Numeric occupancy for a buffer state.
  function automatic logic [OCC_WIDTH-1:0] state_occ(input buf_state_e s);
    case (s)
      S_ONE:   return OCC_WIDTH'(1);
      S_TWO:   return OCC_WIDTH'(2);
      default: return OCC_WIDTH'(0);
    endcase
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order register buffer with push/pop/clear and occupancy.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_WIDTH-1:0]  occ
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // State and entry registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next state: occupancy follows occ + push - pop, clear wins.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (clear) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            head_d  = din;
          end
        end
        S_ONE: begin
          case ({push, pop})
            2'b10: begin
              state_d = S_TWO;
              tail_d  = din;
            end
            2'b01: state_d = S_EMPTY;
            2'b11: head_d = din;
            default: ;
          endcase
        end
        S_TWO: begin
          if (pop) begin
            head_d = tail_q;
            if (push) begin
              tail_d = din;
            end else begin
              state_d = S_ONE;
            end
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign valid = (state_q != S_EMPTY);
  assign head  = head_q;
  assign occ   = state_occ(state_q);

  // A returning word must always find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(push && !pop && !clear && state_q == S_TWO));

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port (data one cycle after rd_en).
module sync_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == CW'(0));
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= data_in;
  end

  // Pointers, count and the registered read word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        data_out <= mem[rd_ptr_q];
      end
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/sync_fifo_reader.sv
// Drains sync_fifo and presents its words as a valid/ready stream.
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int unsigned SUM_WIDTH = 3;

  logic                 inflight_q;
  logic                 drop_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;
  logic                 pop;
  logic                 push;
  logic [OCC_WIDTH-1:0] occ;
  logic [SUM_WIDTH-1:0] pending;

  assign pop  = m_valid & m_ready;
  assign push = inflight_q & ~drop_q;

  // Slots committed after this edge: buffered plus returning minus leaving.
  always_comb begin
    pending = SUM_WIDTH'(occ) + SUM_WIDTH'(inflight_q) - SUM_WIDTH'(pop);
  end

  // Issue a read only when the returning word is guaranteed a slot.
  assign fifo_rd_en = n_rst & ~fifo_empty & ~flush & (pending < SUM_WIDTH'(2));

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (fifo_data),
    .valid (m_valid),
    .head  (m_data),
    .occ   (occ)
  );

  // Read tracking, post-flush discard guard and delivered-word counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      drop_q     <= flush & inflight_q;
      if (pop) word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign word_cnt = word_cnt_q;

  // Never strobe the FIFO while it reports empty.
  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (!n_rst)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Scoreboard bench: sync_fifo feeding sync_fifo_reader.
module tb_sync_fifo_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          n_rst;
  logic          fifo_rst_n;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] word_cnt;

  int            n_checks;
  int            n_err;
  int            rd_count;
  int            hs_run;
  int            max_run;
  logic [CW-1:0] cnt_model;
  logic          prev_hold;
  logic          prev_flush;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] exp_q [$];

  sync_fifo #(
    .FIFO_DEPTH (16),
    .FIFO_WIDTH (DW)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (fifo_rst_n),
    .wr_en    (wr_en),
    .data_in  (din),
    .rd_en    (fifo_rd_en),
    .data_out (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  sync_fifo_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en = 1'b1;
    din   = d;
    exp_q.push_back(d);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  // Output monitor: scoreboard, stream-stability and read-safety checks.
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_hold = 1'b0;
      prev_flush = 1'b0;
      hs_run = 0;
    end else begin
      if (fifo_empty) check_eq("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
      if (prev_hold && !prev_flush) begin
        check_eq("hold_valid", 32'(m_valid), 32'd1);
        check_eq("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (fifo_rd_en) rd_count++;
      if (m_valid && m_ready) begin
        check_eq("word_cnt_track", 32'(word_cnt), 32'(cnt_model));
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        cnt_model = cnt_model + CW'(1);
        hs_run++;
        if (hs_run > max_run) max_run = hs_run;
      end else begin
        hs_run = 0;
      end
      prev_hold  = m_valid && !m_ready;
      prev_flush = flush;
      prev_data  = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_err = 0; rd_count = 0; hs_run = 0; max_run = 0;
    cnt_model = '0; prev_hold = 1'b0; prev_flush = 1'b0; prev_data = '0;
    n_rst = 1'b0; fifo_rst_n = 1'b0; wr_en = 1'b0; din = '0;
    flush = 1'b0; m_ready = 1'b1;
    tick(); tick(); tick();

    // Reset values.
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    check_eq("rst_cnt", 32'(word_cnt), 32'd0);

    // Idle after release with an empty FIFO.
    n_rst = 1'b1; fifo_rst_n = 1'b1;
    repeat (5) tick();
    check_eq("idle_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("idle_valid", 32'(m_valid), 32'd0);
    check_eq("idle_cnt", 32'(word_cnt), 32'd0);

    // Streaming 0x01..0x10 with latency check.
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      push_word(DW'(i + 1));
      tick();
      if (i == 0) begin
        check_eq("lat_rd_en_n", 32'(fifo_rd_en), 32'd1);
        check_eq("lat_valid_n", 32'(m_valid), 32'd0);
      end
      if (i == 1) check_eq("lat_valid_n1", 32'(m_valid), 32'd0);
      if (i == 2) check_eq("lat_valid_n2", 32'(m_valid), 32'd1);
    end
    wr_en = 1'b0;
    drain("stream_drain");
    check_eq("stream_run", 32'(max_run >= 16), 32'd1);
    check_eq("stream_cnt", 32'(word_cnt), 32'd16);

    // Stall: only two reads outstanding while m_ready is low.
    m_ready = 1'b0;
    rd_count = 0;
    for (int i = 0; i < 4; i++) begin
      push_word(8'hA0 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    repeat (6) tick();
    check_eq("stall_reads", 32'(rd_count), 32'd2);
    check_eq("stall_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("stall_valid", 32'(m_valid), 32'd1);
    check_eq("stall_data", 32'(m_data), 32'hA0);
    m_ready = 1'b1;
    drain("stall_drain");
    check_eq("stall_cnt", 32'(word_cnt), 32'd20);

    // Toggling m_ready.
    for (int k = 0; k < 60; k++) begin
      if (k < 8) begin
        push_word(8'hB0 + 8'(k));
      end else begin
        wr_en = 1'b0;
        if (exp_q.size() == 0) break;
      end
      m_ready = (k % 2 == 0);
      tick();
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    drain("toggle_drain");
    check_eq("toggle_cnt", 32'(word_cnt), 32'd28);

    // Flush while one word is buffered and one is returning.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(8'hC0 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    flush = 1'b1;
    m_ready = 1'b0;
    #1;
    check_eq("flush_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("flush_pre_valid", 32'(m_valid), 32'd1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick();
    flush = 1'b0;
    check_eq("flush_valid", 32'(m_valid), 32'd0);
    check_eq("flush_cnt", 32'(word_cnt), 32'd29);
    m_ready = 1'b1;
    push_word(8'hC4);
    tick();
    push_word(8'hC5);
    tick();
    wr_en = 1'b0;
    drain("flush_drain");
    check_eq("flush_post_cnt", 32'(word_cnt), 32'd32);

    // Asynchronous reset with two words buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(8'hD0 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    repeat (4) tick();
    check_eq("prerst_valid", 32'(m_valid), 32'd1);
    check_eq("prerst_data", 32'(m_data), 32'hD0);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("arst_valid", 32'(m_valid), 32'd0);
    check_eq("arst_data", 32'(m_data), 32'd0);
    check_eq("arst_cnt", 32'(word_cnt), 32'd0);
    check_eq("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    cnt_model = '0;
    tick();
    n_rst = 1'b1;
    m_ready = 1'b1;
    drain("rst_drain");
    check_eq("rst_post_cnt", 32'(word_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
